// File: rtl/keypad_encoder_pkg.sv
// Shared types and helpers for the parametrised keypad encoder.
package keypad_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    ACCEPT,
    HOLD,
    REL_DB
  } state_t;

  // Number of bits needed to hold the value n (at least 1).
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) <= n) w = i + 1;
    end
    return w;
  endfunction

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [5:0] lowest_set(input logic [63:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_encoder_n_mod_n.sv
// Free-running modulus-DIV counter; o_tick is high for the single cycle at DIV-1.
import keypad_encoder_pkg::*;

module mod_n #(
  parameter int DIV = 100
) (
  input  logic i_clk,
  input  logic i_rstn,
  output logic o_tick
);

  localparam int CW = cnt_width(DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (r_count == CW'(DIV - 1)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tick = (r_count == CW'(DIV - 1));

endmodule

// File: rtl/keypad_encoder_n.sv
// Synchronising, debouncing priority keypad encoder with load strobe and divider-driven pgt.
// Optional auto-repeat while a key is held is enabled by defining KEY_AUTOREPEAT_EN.
import keypad_encoder_pkg::*;

module keypad_encoder_n #(
  parameter int N_KEYS          = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DIV             = 100,
  parameter int REPEAT_CYCLES   = 500
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_KEYS-1:0] key,
  input  logic              enbn,
  output logic [CODE_W-1:0] D,
  output logic              loadn,
  output logic              pgt
);

  localparam int DBW = cnt_width(DEBOUNCE_CYCLES);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  state_t            r_state;
  state_t            w_next;
  logic [DBW-1:0]    r_count;
  logic [DBW-1:0]    w_count_next;
  logic [CODE_W-1:0] r_latched;
  logic [CODE_W-1:0] w_latched_next;
  logic [CODE_W-1:0] r_code;
  logic              r_loadn;
  logic              r_pgt;
  logic              w_any;
  logic [63:0]       w_key_ext;
  logic [5:0]        w_idx;
  logic [CODE_W-1:0] w_cand;
  logic              w_tick;
  logic              w_accept_next;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPW = cnt_width(REPEAT_CYCLES);
  logic [RPW-1:0] r_rep;
  logic [RPW-1:0] w_rep_next;
`else
  logic w_unused_repeat;
  assign w_unused_repeat = (REPEAT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_any     = |r_sync2;
  assign w_key_ext = 64'(r_sync2);
  assign w_idx     = lowest_set(w_key_ext);
  assign w_cand    = CODE_W'(w_idx);

  mod_n #(.DIV(DIV)) u_div (
    .i_clk  (clk),
    .i_rstn (rstn),
    .o_tick (w_tick)
  );

  // Disabling the keypad overrides every state and restarts debouncing from scratch.
  always_comb begin
    w_next         = r_state;
    w_count_next   = r_count;
    w_latched_next = r_latched;
`ifdef KEY_AUTOREPEAT_EN
    w_rep_next     = r_rep;
`endif
    if (enbn) begin
      w_next       = IDLE;
      w_count_next = '0;
`ifdef KEY_AUTOREPEAT_EN
      w_rep_next   = '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          w_count_next = '0;
          if (w_any) begin
            w_latched_next = w_cand;
            w_next         = PRESS_DB;
            w_count_next   = DBW'(1);
          end
        end
        PRESS_DB: begin
          if (w_any && (w_cand == r_latched)) begin
            if (r_count >= DBW'(DEBOUNCE_CYCLES)) w_next = ACCEPT;
            else w_count_next = r_count + DBW'(1);
          end else begin
            w_next       = IDLE;
            w_count_next = '0;
          end
        end
        ACCEPT: begin
          w_next       = HOLD;
          w_count_next = '0;
`ifdef KEY_AUTOREPEAT_EN
          w_rep_next   = '0;
`endif
        end
        HOLD: begin
          if (!w_any) begin
            w_next       = REL_DB;
            w_count_next = DBW'(1);
`ifdef KEY_AUTOREPEAT_EN
            w_rep_next   = '0;
          end else if (w_cand != r_latched) begin
            w_rep_next = '0;
          end else if (r_rep == RPW'(REPEAT_CYCLES - 1)) begin
            w_next     = ACCEPT;
            w_rep_next = '0;
          end else begin
            w_rep_next = r_rep + RPW'(1);
`endif
          end
        end
        REL_DB: begin
          if (w_any) begin
            w_next       = HOLD;
            w_count_next = '0;
          end else if (r_count >= DBW'(DEBOUNCE_CYCLES)) begin
            w_next       = IDLE;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + DBW'(1);
          end
        end
        default: begin
          w_next       = IDLE;
          w_count_next = '0;
        end
      endcase
    end
  end

  assign w_accept_next = (w_next == ACCEPT);

  // Strobes are registered from the next state so they line up with the ACCEPT cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_latched <= '0;
      r_code    <= '0;
      r_loadn   <= 1'b1;
      r_pgt     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_count   <= w_count_next;
      r_latched <= w_latched_next;
      r_loadn   <= !w_accept_next;
      r_pgt     <= enbn ? w_tick : w_accept_next;
      if (w_accept_next) r_code <= w_latched_next;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rep <= '0;
    else r_rep <= w_rep_next;
  end
`endif

  assign D     = r_code;
  assign loadn = r_loadn;
  assign pgt   = r_pgt;

endmodule

// File: tb/tb_keypad_encoder_n.sv
// Scoreboard bench for keypad_encoder_n: expected strobes are queued at stimulus time and matched per cycle.
module tb_keypad_encoder_n;

  localparam int NK  = 10;
  localparam int CW  = 4;
  localparam int DB  = 16;
  localparam int DV  = 100;
  localparam int RPT = 50;

  logic          clk;
  logic          rstn;
  logic [NK-1:0] key;
  logic          enbn;
  logic [CW-1:0] D;
  logic          loadn;
  logic          pgt;

  typedef struct {
    int cyc;
    int code;
  } exp_t;

  exp_t q[$];
  int   totalChecks = 0;
  int   badChecks   = 0;
  int   cyc         = 0;
  int   divModel    = 0;
  logic expPgtDiv   = 1'b0;
  logic enAtEdge    = 1'b1;
  int   holdLong;
  int   m;

  keypad_encoder_n #(
    .N_KEYS          (NK),
    .CODE_W          (CW),
    .DEBOUNCE_CYCLES (DB),
    .DIV             (DV),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .key   (key),
    .enbn  (enbn),
    .D     (D),
    .loadn (loadn),
    .pgt   (pgt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    totalChecks++;
    if (obs !== expv) begin
      badChecks++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [NK-1:0] k);
    key = k;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expectStrobe(input int atCyc, input int code);
    exp_t e;
    e.cyc  = atCyc;
    e.code = code;
    q.push_back(e);
  endtask

  // Reference divider: pgt in disabled mode is the tick of the count seen at the previous edge.
  always @(posedge clk) begin
    cyc++;
    enAtEdge = enbn;
    if (rstn) begin
      expPgtDiv = (divModel == DV - 1);
      divModel  = (divModel + 1) % DV;
    end else begin
      expPgtDiv = 1'b0;
      divModel  = 0;
    end
  end

  always @(negedge clk) begin
    logic expStrobe;
    int   expCode;
    if (rstn) begin
      expStrobe = 1'b0;
      expCode   = 0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checkOutput("missedStrobe", 64'(cyc), 64'(q[0].cyc));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        expStrobe = 1'b1;
        expCode   = q[0].code;
        void'(q.pop_front());
      end
      if (enAtEdge) begin
        checkOutput("pgtDiv", 64'(pgt), 64'(expPgtDiv));
        checkOutput("loadnDisabled", 64'(loadn), 64'd1);
      end else begin
        checkOutput("loadn", 64'(loadn), 64'(!expStrobe));
        checkOutput("pgtAccept", 64'(pgt), 64'(expStrobe));
        if (expStrobe) checkOutput("code", 64'(D), 64'(expCode));
      end
    end
  end

  initial begin
    rstn = 1'b0;
    enbn = 1'b1;
    key  = NK'($urandom);
    @(posedge clk);
    #2;
    waitCycles(3);
    checkOutput("resetD", 64'(D), 64'd0);
    checkOutput("resetLoadn", 64'(loadn), 64'd1);
    checkOutput("resetPgt", 64'(pgt), 64'd0);

    // Disabled keypad: divider ticks only.
    applyStimulus('0);
    rstn = 1'b1;
    waitCycles(250);

    // Single held key with the expected pipeline latency.
    enbn = 1'b0;
    waitCycles(5);
`ifdef KEY_AUTOREPEAT_EN
    holdLong = 40;
`else
    holdLong = 1000;
`endif
    applyStimulus(NK'(1) << 7);
    expectStrobe(cyc + 2 + DB + 1, 7);
    waitCycles(holdLong);
    applyStimulus('0);
    waitCycles(40);

    // Bouncing key never survives the debounce window.
    for (int t = 0; t < 12; t++) begin
      applyStimulus(key ^ (NK'(1) << 3));
      waitCycles(5);
    end
    applyStimulus(NK'(1) << 3);
    expectStrobe(cyc + 2 + DB + 1, 3);
    waitCycles(30);
    applyStimulus('0);
    waitCycles(40);

    // Priority and no re-accept until full release.
    applyStimulus((NK'(1) << 2) | (NK'(1) << 5));
    expectStrobe(cyc + 2 + DB + 1, 2);
    waitCycles(40);
    applyStimulus(NK'(1) << 5);
    waitCycles(40);
    applyStimulus('0);
    waitCycles(40);
    applyStimulus(NK'(1) << 5);
    expectStrobe(cyc + 2 + DB + 1, 5);
    waitCycles(30);
    applyStimulus('0);
    waitCycles(40);

    // Reset mid-debounce discards the press.
    applyStimulus(NK'(1) << 1);
    waitCycles(10);
    rstn = 1'b0;
    applyStimulus('0);
    waitCycles(3);
    checkOutput("midResetD", 64'(D), 64'd0);
    checkOutput("midResetLoadn", 64'(loadn), 64'd1);
    checkOutput("midResetPgt", 64'(pgt), 64'd0);
    rstn = 1'b1;
    waitCycles(40);

    // Disable at debounce count 10, then re-enable with the key still held.
    applyStimulus(NK'(1) << 4);
    waitCycles(12);
    enbn = 1'b1;
    waitCycles(1);
    checkOutput("codeHeld", 64'(D), 64'd0);
    waitCycles(250);
    enbn = 1'b0;
    m = cyc;
    expectStrobe(m + 1 + DB, 4);
    waitCycles(30);
    applyStimulus('0);
    waitCycles(40);

`ifdef KEY_AUTOREPEAT_EN
    // Auto-repeat period is REPEAT_CYCLES of HOLD plus the ACCEPT cycle.
    applyStimulus(NK'(1) << 9);
    m = cyc + 2 + DB + 1;
    for (int r = 0; r < 4; r++) expectStrobe(m + r * (RPT + 1), 9);
    waitCycles(2 + DB + 1 + 200);
    applyStimulus('0);
    waitCycles(40);
`endif

    waitCycles(20);
    checkOutput("pendingStrobes", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
